mem_arbiter: RTL

Two-requester arbiter that shares the single data-memory port between the CPU MEM stage and a debug/DMA master. The CPU has fixed priority. A starvation counter guarantees the debug master a slot after a bounded number of consecutive CPU wins. When the debug master wins while the CPU is requesting, the arbiter stalls the pipeline. The block sits between the EX/MEM register outputs and the data memory.

---
 rtl/mem_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/debug data-memory port arbiter with bounded debug starvation
// Optional statistics counters enabled by defining MEM_ARB_STATS_EN.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_load,
    input  logic              cpu_store,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [2:0]        cpu_type,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_load,
    output logic              mem_store,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_type,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_dbg_grants,
    output logic [15:0]       stat_stall_cycles
`endif
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic       cpu_req;
    logic       dbg_elig;
    logic       grant_dbg;
    logic       grant_cpu;

    // The ack cycle locks debug out so a still-held request cannot run twice.
    assign cpu_req   = cpu_load | cpu_store;
    assign dbg_elig  = dbg_req & ~dbg_ack;
    assign grant_dbg = dbg_elig & (~cpu_req | (starve_cnt == STARVE_LIM));
    assign grant_cpu = cpu_req & ~grant_dbg;
    assign cpu_stall = cpu_req & grant_dbg;

    always_comb begin
        mem_load  = 1'b0;
        mem_store = 1'b0;
        mem_addr  = '0;
        mem_type  = 3'b000;
        mem_wdata = '0;
        cpu_rdata = '0;
        if (grant_cpu) begin
            mem_load  = cpu_load;
            mem_store = cpu_store;
            mem_addr  = cpu_addr;
            mem_type  = cpu_type;
            mem_wdata = cpu_wdata;
            cpu_rdata = mem_rdata;
        end else if (grant_dbg) begin
            mem_load  = ~dbg_we;
            mem_store = dbg_we;
            mem_addr  = dbg_addr;
            mem_type  = 3'b010;
            mem_wdata = dbg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= 4'd0;
        end else if (grant_dbg || !dbg_req) begin
            starve_cnt <= 4'd0;
        end else if (grant_cpu && dbg_elig && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            dbg_ack <= grant_dbg;
            if (grant_dbg && !dbg_we) begin
                dbg_rdata <= mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_dbg_grants   <= 16'd0;
            stat_stall_cycles <= 16'd0;
        end else begin
            if (grant_dbg && stat_dbg_grants != 16'hFFFF) begin
                stat_dbg_grants <= stat_dbg_grants + 16'd1;
            end
            if (cpu_stall && stat_stall_cycles != 16'hFFFF) begin
                stat_stall_cycles <= stat_stall_cycles + 16'd1;
            end
        end
    end
`endif

endmodule
